// File: rtl/lane_stripe_ctrl.sv
// Two-lane byte striper: accepted bytes alternate between lane 0 and lane 1
// (or all go to lane 0 in x1 mode), and odd-length packets get a pad on lane 1.
module lane_stripe_ctrl #(
  parameter logic [7:0] PAD_BYTE = 8'hF7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        x1_mode,
  input  logic        validIn,
  input  logic [7:0]  In0,
  input  logic        eop,
  input  logic [1:0]  lane_ready,
  output logic        in_ready,
  output logic [7:0]  data_out0,
  output logic [7:0]  data_out1,
  output logic        outValid0,
  output logic        outValid1,
  output logic        lane_sel,
  output logic        busy,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAD    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        lane_sel_q, lane_sel_d;
  logic        mode_q, mode_d;
  logic        valid0_q, valid0_d;
  logic        valid1_q, valid1_d;
  logic [7:0]  data0_q, data0_d;
  logic [7:0]  data1_q, data1_d;
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  logic xfer;
  logic eff_mode;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    in_ready = enable & lane_ready[0];
        ACTIVE:  in_ready = lane_ready[lane_sel_q];
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign xfer = validIn & in_ready;

  // The first byte of a packet is steered by the live x1_mode; later bytes by the latched copy.
  assign eff_mode = (state_q == IDLE) ? x1_mode : mode_q;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    lane_sel_d = lane_sel_q;
    mode_d     = mode_q;
    valid0_d   = 1'b0;
    valid1_d   = 1'b0;
    data0_d    = data0_q;
    data1_d    = data1_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;

    if (xfer) begin
      if (lane_sel_q) begin
        data1_d  = In0;
        valid1_d = 1'b1;
        cnt1_d   = sat_inc(cnt1_q);
      end else begin
        data0_d  = In0;
        valid0_d = 1'b1;
        cnt0_d   = sat_inc(cnt0_q);
      end
      lane_sel_d = eff_mode ? 1'b0 : ~lane_sel_q;
    end

    case (state_q)
      IDLE: begin
        if (xfer) begin
          mode_d = x1_mode;
          if (!eop)         state_d = ACTIVE;
          else if (x1_mode) state_d = IDLE;
          else              state_d = PAD;
        end
      end
      ACTIVE: begin
        // A last byte that landed on lane 0 leaves lane 1 one short, so it needs a pad.
        if (xfer && eop) begin
          state_d = (!mode_q && !lane_sel_q) ? PAD : IDLE;
        end
      end
      PAD: begin
        if (lane_ready[1]) begin
          data1_d    = PAD_BYTE;
          valid1_d   = 1'b1;
          cnt1_d     = sat_inc(cnt1_q);
          lane_sel_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lane_sel_q <= 1'b0;
      mode_q     <= 1'b0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      data0_q    <= 8'h00;
      data1_q    <= 8'h00;
      cnt0_q     <= 16'h0000;
      cnt1_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      lane_sel_q <= lane_sel_d;
      mode_q     <= mode_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign data_out0 = data0_q;
  assign data_out1 = data1_q;
  assign outValid0 = valid0_q;
  assign outValid1 = valid1_q;
  assign lane_sel  = lane_sel_q;
  assign busy      = (state_q != IDLE);
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

  a_no_overlap: assert property (@(posedge clk) disable iff (reset)
    !(valid0_q && valid1_q));
  a_idle_on_lane0: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE) |-> !lane_sel_q);
  a_pad_on_lane1: assert property (@(posedge clk) disable iff (reset)
    (state_q == PAD) |-> (lane_sel_q && !in_ready));

endmodule

// File: tb/tb_lane_stripe_ctrl.sv
// Scoreboard bench for lane_stripe_ctrl: packets are turned into expected per-lane
// byte streams up front, and a monitor pops them as the lanes pulse valid.
module tb_lane_stripe_ctrl;

  localparam logic [7:0] PAD = 8'hF7;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        x1_mode;
  logic        validIn;
  logic [7:0]  In0;
  logic        eop;
  logic [1:0]  lane_ready;
  logic        in_ready;
  logic [7:0]  data_out0, data_out1;
  logic        outValid0, outValid1;
  logic        lane_sel;
  logic        busy;
  logic [15:0] cnt0, cnt1;

  int errors = 0;
  int total  = 0;

  logic [7:0]  exp0[$];
  logic [7:0]  exp1[$];
  logic [7:0]  pkt_q[$];
  logic [15:0] m_cnt0, m_cnt1;

  lane_stripe_ctrl #(.PAD_BYTE(PAD)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .x1_mode    (x1_mode),
    .validIn    (validIn),
    .In0        (In0),
    .eop        (eop),
    .lane_ready (lane_ready),
    .in_ready   (in_ready),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .outValid0  (outValid0),
    .outValid1  (outValid1),
    .lane_sel   (lane_sel),
    .busy       (busy),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bump(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Reference: bytes alternate lanes starting on lane 0 (x2) or all go to lane 0 (x1);
  // a complete odd-length x2 packet is topped up with one pad on lane 1.
  task automatic model_packet(input logic mode, input bit complete);
    for (int i = 0; i < pkt_q.size(); i++) begin
      if (mode || (i % 2 == 0)) begin
        exp0.push_back(pkt_q[i]);
        m_cnt0 = bump(m_cnt0);
      end else begin
        exp1.push_back(pkt_q[i]);
        m_cnt1 = bump(m_cnt1);
      end
    end
    if (complete && !mode && (pkt_q.size() % 2 == 1)) begin
      exp1.push_back(PAD);
      m_cnt1 = bump(m_cnt1);
    end
  endtask

  // Monitor: compares every lane pulse against the head of that lane's queue.
  always @(negedge clk) begin
    logic [7:0] e;
    if (outValid0) begin
      if (exp0.size() == 0) check("lane0_unexpected", 32'(outValid0), 32'd0);
      else begin
        e = exp0.pop_front();
        check("lane0_data", 32'(data_out0), 32'(e));
      end
    end
    if (outValid1) begin
      check("lane_overlap", 32'(outValid0), 32'd0);
      if (exp1.size() == 0) check("lane1_unexpected", 32'(outValid1), 32'd0);
      else begin
        e = exp1.pop_front();
        check("lane1_data", 32'(data_out1), 32'(e));
      end
    end
  end

  task automatic check_reset_state();
    check("rst_outValid0", 32'(outValid0), 32'd0);
    check("rst_outValid1", 32'(outValid1), 32'd0);
    check("rst_data_out0", 32'(data_out0), 32'd0);
    check("rst_data_out1", 32'(data_out1), 32'd0);
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lane_sel", 32'(lane_sel), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; validIn = 1'b0; eop = 1'b0; In0 = 8'h00;
    enable = 1'b1; lane_ready = 2'b11; x1_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp0.delete(); exp1.delete();
    m_cnt0 = 16'd0; m_cnt1 = 16'd0;
    reset = 1'b0;
  endtask

  // Presents one byte and returns on the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input logic e, input bit rnd);
    int waited = 0;
    bit done = 1'b0;
    validIn = 1'b1; In0 = b; eop = e;
    while (!done) begin
      if (rnd) begin
        lane_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        enable     = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (in_ready || waited >= 200) done = 1'b1;
      else begin
        waited++;
        @(negedge clk);
      end
    end
    check("accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    validIn = 1'b0; eop = 1'b0;
  endtask

  task automatic send_packet(input logic mode, input bit flip, input bit rnd);
    int last = pkt_q.size() - 1;
    model_packet(mode, 1'b1);
    x1_mode = mode;
    for (int i = 0; i <= last; i++) begin
      send_byte(pkt_q[i], (i == last), rnd);
      if (flip && i == 0) x1_mode = ~mode;
      if (i != last) begin
        check("lane_sel_mid", 32'(lane_sel), mode ? 32'd0 : 32'((i + 1) % 2));
        check("busy_mid", 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    validIn = 1'b0; lane_ready = 2'b11;
    #2;
    while (n < 100 && (busy || exp0.size() != 0 || exp1.size() != 0)) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("drained", {29'd0, busy, exp0.size() != 0, exp1.size() != 0}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    reset = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    reset = 1'b0;

    // Even-length x2 packet: clean stripe, no pad.
    do_reset();
    pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_packet(1'b0, 1'b0, 1'b0);
    check("x2_end_busy", 32'(busy), 32'd0);
    check("x2_end_lane_sel", 32'(lane_sel), 32'd0);
    drain();
    check("x2_cnt0", 32'(cnt0), 32'd2);
    check("x2_cnt1", 32'(cnt1), 32'd2);

    // Odd-length x2 packet: one pad cycle with in_ready low.
    do_reset();
    pkt_q = '{8'hA1, 8'hA2, 8'hA3};
    send_packet(1'b0, 1'b0, 1'b0);
    #1;
    check("pad_in_ready", 32'(in_ready), 32'd0);
    check("pad_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check("post_pad_in_ready", 32'(in_ready), 32'd1);
    check("post_pad_busy", 32'(busy), 32'd0);
    drain();
    check("odd_cnt0", 32'(cnt0), 32'd2);
    check("odd_cnt1", 32'(cnt1), 32'd2);

    // x1 packet with x1_mode dropped after the first byte.
    do_reset();
    pkt_q = '{8'hC1, 8'hC2, 8'hC3};
    send_packet(1'b1, 1'b1, 1'b0);
    check("x1_end_busy", 32'(busy), 32'd0);
    check("x1_end_lane_sel", 32'(lane_sel), 32'd0);
    drain();
    check("x1_cnt0", 32'(cnt0), 32'd3);
    check("x1_cnt1", 32'(cnt1), 32'd0);

    // Single-byte x2 packet held in PAD by lane 1 backpressure.
    do_reset();
    pkt_q = '{8'hB1};
    send_packet(1'b0, 1'b0, 1'b0);
    lane_ready = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("bp_no_pad", 32'(outValid1), 32'd0);
    end
    lane_ready = 2'b11;
    @(negedge clk);
    check("bp_pad_valid", 32'(outValid1), 32'd1);
    check("bp_pad_data", 32'(data_out1), 32'(PAD));
    check("bp_pad_busy", 32'(busy), 32'd0);
    drain();
    check("bp_cnt0", 32'(cnt0), 32'd1);
    check("bp_cnt1", 32'(cnt1), 32'd1);

    // Reset after two bytes of an unfinished packet: no pad, next packet starts on lane 0.
    do_reset();
    pkt_q = '{8'h5A, 8'hA5};
    model_packet(1'b0, 1'b0);
    x1_mode = 1'b0;
    send_byte(pkt_q[0], 1'b0, 1'b0);
    send_byte(pkt_q[1], 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;
    m_cnt0 = 16'd0; m_cnt1 = 16'd0;
    pkt_q = '{8'hD1, 8'hD2};
    send_packet(1'b0, 1'b0, 1'b0);
    check("rst_pkt_end_busy", 32'(busy), 32'd0);
    drain();
    check("rst_pkt_cnt0", 32'(cnt0), 32'd1);
    check("rst_pkt_cnt1", 32'(cnt1), 32'd1);

    // Randomized packets with random backpressure, enable and mid-packet mode flips.
    do_reset();
    for (int p = 0; p < 40; p++) begin
      int len = $urandom_range(1, 9);
      pkt_q.delete();
      for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
      send_packet(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();
    check("rand_cnt0", 32'(cnt0), 32'(m_cnt0));
    check("rand_cnt1", 32'(cnt1), 32'(m_cnt1));

    // Counter saturation: 65537 lane-0 bytes in x1 mode.
    do_reset();
    pkt_q.delete();
    for (int i = 0; i < 65537; i++) pkt_q.push_back(8'($urandom));
    send_packet(1'b1, 1'b0, 1'b0);
    drain();
    check("sat_cnt0", 32'(cnt0), 32'h0000_FFFF);
    check("sat_cnt1", 32'(cnt1), 32'd0);
    check("sat_model_cnt0", 32'(cnt0), 32'(m_cnt0));

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
